// File: rtl/seg_pkg.sv
// Shared display-side types, constants and helpers for the 7-segment path.
// Latency: n/a (declarations and a pure combinational function).
// Backpressure: n/a.
package seg_pkg;

    // Default number of scanned digits.
    localparam int DIGITS = 8;

    // Widest value msd_index can inspect. Callers zero-extend narrower values.
    localparam int MAX_DIGITS = 16;

    typedef logic [3:0] nibble_t;

    // All anodes off (anodes are active-low).
    localparam logic [DIGITS-1:0] AN_OFF = '1;

    // Index of the highest non-zero nibble; 0 when the whole value is zero.
    function automatic nibble_t msd_index(input logic [4*MAX_DIGITS-1:0] v);
        nibble_t m;
        m = '0;
        for (int k = 0; k < MAX_DIGITS; k++) begin
            if (v[4*k +: 4] != 4'h0) begin
                m = nibble_t'(k);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Divides core_clk into one tick per SCAN_DIV cycles to pace the digit scan.
// Latency: tick is combinational from the count; first tick SCAN_DIV-1 cycles after enable.
// Backpressure: none; enable low parks the count at 0 and suppresses tick.
module scan_prescaler #(
    parameter int SCAN_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Tick on the last count of a slot; count restarts after it and parks at 0 when disabled.
    always_comb begin
        tick  = enable && (cnt_q == CNT_LAST);
        cnt_d = '0;
        if (enable && !tick) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed hex digit scanner feeding a 7-segment decoder, with frame-synchronous value updates.
// Latency: num/an registered one cycle after idx moves; load visible after 1 cycle (best) to 1 frame + 1 cycle (worst).
// Backpressure: none; load always accepted, a later load before the frame boundary replaces the staged one.
module seg_scan_mux #(
    parameter int DIGITS      = seg_pkg::DIGITS,
    parameter int SCAN_DIV    = 100000,
    parameter bit LZ_SUPPRESS = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    output logic [3:0]            num,
    output logic [DIGITS-1:0]     an,
    output logic                  pending,
    output logic                  frame_done
);

    import seg_pkg::*;

    // DIGITS is limited to MAX_DIGITS (16) by the width of msd_index.
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic                  tick;
    logic                  wrap;

    logic                  run_q,        run_d;
    logic [IDX_W-1:0]      idx_q,        idx_d;
    logic [4*DIGITS-1:0]   staged_q,     staged_d;
    logic [4*DIGITS-1:0]   shadow_q,     shadow_d;
    logic                  pending_q,    pending_d;
    logic                  frame_done_q, frame_done_d;
    nibble_t               num_q,        num_d;
    logic [DIGITS-1:0]     an_q,         an_d;

    logic [4*MAX_DIGITS-1:0] shadow_ext;
    nibble_t                 msd;
    nibble_t                 idx_n;

    scan_prescaler #(
        .SCAN_DIV (SCAN_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .tick   (tick)
    );

    // Scan index: the first tick after reset opens slot 0, later ticks step through the digits.
    always_comb begin
        run_d = run_q | tick;
        wrap  = tick && run_q && (idx_q == IDX_LAST);
        idx_d = idx_q;
        if (tick && run_q) begin
            idx_d = wrap ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Staging and commit: loads wait for the frame boundary unless they coincide with it or the scan is stopped.
    always_comb begin
        staged_d     = staged_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        frame_done_d = wrap;
        if (load) begin
            staged_d = value;
        end
        if (load && (!enable || wrap)) begin
            shadow_d  = value;
            pending_d = 1'b0;
        end else if (load) begin
            pending_d = 1'b1;
        end else if (wrap) begin
            shadow_d  = staged_q;
            pending_d = 1'b0;
        end
    end

    // Output stage: pick the current nibble, drive its anode low, blank leading zeros above the top digit.
    always_comb begin
        shadow_ext                   = '0;
        shadow_ext[4*DIGITS-1:0]     = shadow_q;
        msd                          = msd_index(shadow_ext);
        idx_n                        = nibble_t'(idx_q);
        num_d                        = num_q;
        an_d                         = '1;
        if (enable && run_q) begin
            num_d = shadow_q[{idx_q, 2'b00} +: 4];
            an_d  = ~(DIGITS'(1) << idx_q);
            if (LZ_SUPPRESS && (idx_n > msd)) begin
                an_d = '1;
            end
        end
    end

    // State and output registers; reset discards any staged value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q        <= 1'b0;
            idx_q        <= '0;
            staged_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            num_q        <= '0;
            an_q         <= '1;
        end else begin
            run_q        <= run_d;
            idx_q        <= idx_d;
            staged_q     <= staged_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            num_q        <= num_d;
            an_q         <= an_d;
        end
    end

    assign num        = num_q;
    assign an         = an_q;
    assign pending    = pending_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: two instances (leading-zero suppression off/on) driven with shared stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_seg_scan_mux;

    localparam int D  = 4;
    localparam int SD = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] value;

    logic [3:0]  num_nz, num_lz;
    logic [3:0]  an_nz,  an_lz;
    logic        pend_nz, pend_lz;
    logic        fd_nz,   fd_lz;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    // Behavioural model state.
    int          m_pcnt;
    int          m_ticks;
    logic [15:0] m_shadow, m_staged;
    logic        m_pend, m_fd;
    logic [3:0]  m_num, m_an_nz, m_an_lz;

    seg_scan_mux #(.DIGITS(D), .SCAN_DIV(SD), .LZ_SUPPRESS(1'b0)) dut_nz (
        .clk(clk), .rst_n(rst_n), .enable(enable), .value(value), .load(load),
        .num(num_nz), .an(an_nz), .pending(pend_nz), .frame_done(fd_nz)
    );

    seg_scan_mux #(.DIGITS(D), .SCAN_DIV(SD), .LZ_SUPPRESS(1'b1)) dut_lz (
        .clk(clk), .rst_n(rst_n), .enable(enable), .value(value), .load(load),
        .num(num_lz), .an(an_lz), .pending(pend_lz), .frame_done(fd_lz)
    );

    always #5 clk = ~clk;

    task automatic chk4(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, want %b at %0t", nm, act, exp, $time);
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, want %b at %0t", nm, act, exp, $time);
    endtask

    function automatic int msd(input logic [15:0] v);
        int m;
        m = 0;
        for (int k = 0; k < D; k++) if (v[4*k +: 4] != 4'h0) m = k;
        return m;
    endfunction

    task automatic model_reset();
        m_pcnt = 0; m_ticks = 0; m_shadow = '0; m_staged = '0;
        m_pend = 1'b0; m_fd = 1'b0; m_num = '0; m_an_nz = 4'hF; m_an_lz = 4'hF;
    endtask

    // Time-based model: slot position follows from the number of ticks since reset.
    task automatic model_step();
        int k;
        bit tk, wr;
        if (enable && m_ticks >= 1) begin
            k        = (m_ticks - 1) % D;
            m_num    = m_shadow[4*k +: 4];
            m_an_nz  = 4'hF;
            m_an_nz[k] = 1'b0;
            m_an_lz  = (k > msd(m_shadow)) ? 4'hF : m_an_nz;
        end else begin
            m_an_nz = 4'hF;
            m_an_lz = 4'hF;
        end
        tk = enable && (m_pcnt == SD - 1);
        wr = tk && (m_ticks >= 1) && (m_ticks % D == 0);
        m_pcnt = (enable && !tk) ? m_pcnt + 1 : 0;
        if (tk) m_ticks++;
        m_fd = wr;
        if (load && (!enable || wr)) begin
            m_shadow = value; m_staged = value; m_pend = 1'b0;
        end else if (load) begin
            m_staged = value; m_pend = 1'b1;
        end else if (wr) begin
            m_shadow = m_staged; m_pend = 1'b0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Every cycle: both instances against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk4("num_nz", num_nz, m_num);
            chk4("num_lz", num_lz, m_num);
            chk4("an_nz", an_nz, m_an_nz);
            chk4("an_lz", an_lz, m_an_lz);
            chk1("pend_nz", pend_nz, m_pend);
            chk1("pend_lz", pend_lz, m_pend);
            chk1("fd_nz", fd_nz, m_fd);
            chk1("fd_lz", fd_lz, m_fd);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [3:0] lit_nz  [12] = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7, 4'h7, 4'hE, 4'hE};
    logic [3:0] lit_lz  [12] = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hE, 4'hE};
    logic [3:0] seq_num [4]  = '{4'h4, 4'h3, 4'h2, 4'h1};
    logic [3:0] seq_an  [4]  = '{4'hE, 4'hD, 4'hB, 4'h7};

    initial begin
        rst_n = 1'b1; enable = 1'b0; load = 1'b0; value = '0;
        #1 rst_n = 1'b0;
        step(1);
        cmp_en = 1'b1;
        step(1);
        chk4("rst_an_nz", an_nz, 4'hF);
        chk4("rst_an_lz", an_lz, 4'hF);
        chk4("rst_num", num_nz, 4'h0);
        chk1("rst_pend", pend_nz, 1'b0);

        // Scan order after release.
        rst_n = 1'b1; enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk4("scan_an_nz", an_nz, lit_nz[i]);
            chk4("scan_an_lz", an_lz, lit_lz[i]);
            chk1("scan_fd", fd_nz, (i == 9));
        end

        // Deferred commit of 1234.
        load = 1'b1; value = 16'h1234; step(1); load = 1'b0;
        chk1("defer_pend", pend_nz, 1'b1);
        chk4("defer_old_num", num_nz, 4'h0);
        chk4("defer_old_an", an_nz, 4'hD);
        step(4);
        chk1("defer_pend_hold", pend_nz, 1'b1);
        chk4("defer_last_old", num_nz, 4'h0);
        step(1);
        chk1("defer_fd", fd_nz, 1'b1);
        chk1("defer_pend_clr", pend_nz, 1'b0);
        for (int j = 0; j < 4; j++) begin
            step(j == 0 ? 1 : 2);
            chk4("defer_num", num_nz, seq_num[j]);
            chk4("defer_an", an_nz, seq_an[j]);
        end

        // Double load within a frame; last one (0042) wins, high digits blanked.
        step(1);
        load = 1'b1; value = 16'h1111; step(1);
        value = 16'h0042; step(1); load = 1'b0;
        chk1("dbl_pend", pend_nz, 1'b1);
        step(6);
        chk1("dbl_fd", fd_lz, 1'b1);
        step(1);
        chk4("dbl_num0", num_lz, 4'h2); chk4("dbl_an0", an_lz, 4'hE);
        step(2);
        chk4("dbl_num1", num_lz, 4'h4); chk4("dbl_an1", an_lz, 4'hD);
        step(2);
        chk4("dbl_an2_lz", an_lz, 4'hF); chk4("dbl_an2_nz", an_nz, 4'hB); chk4("dbl_num2", num_lz, 4'h0);
        step(2);
        chk4("dbl_an3_lz", an_lz, 4'hF); chk4("dbl_an3_nz", an_nz, 4'h7);

        // Zero value: only digit 0 lit.
        step(1);
        load = 1'b1; value = 16'h0000; step(1); load = 1'b0;
        step(8);
        chk4("zero_num0", num_lz, 4'h0); chk4("zero_an0", an_lz, 4'hE);
        step(2);
        chk4("zero_an1_lz", an_lz, 4'hF); chk4("zero_an1_nz", an_nz, 4'hD);
        step(4);
        chk4("zero_an3_lz", an_lz, 4'hF);

        // Load on the wrap cycle goes straight to the display.
        load = 1'b1; value = 16'hABCD; step(1); load = 1'b0;
        chk1("bnd_pend", pend_nz, 1'b0);
        chk1("bnd_fd", fd_nz, 1'b1);
        step(1);
        chk4("bnd_num0", num_lz, 4'hD); chk4("bnd_an0", an_lz, 4'hE); chk1("bnd_pend2", pend_lz, 1'b0);
        step(2);
        chk4("bnd_num1", num_lz, 4'hC); chk4("bnd_an1", an_lz, 4'hD);

        // Load while disabled commits immediately; anodes blank, num holds.
        enable = 1'b0; load = 1'b1; value = 16'h5555; step(1); load = 1'b0;
        chk4("dis_an_nz", an_nz, 4'hF); chk4("dis_an_lz", an_lz, 4'hF);
        chk4("dis_num_hold", num_nz, 4'hC); chk1("dis_pend", pend_nz, 1'b0);
        step(2);
        chk4("dis_an_hold", an_nz, 4'hF);
        enable = 1'b1; step(1);
        chk4("reen_num", num_nz, 4'h5); chk4("reen_an", an_nz, 4'hD);

        // Asynchronous reset while a value is staged.
        load = 1'b1; value = 16'h9876; step(1); load = 1'b0;
        chk1("ar_pend_pre", pend_nz, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk4("ar_an", an_nz, 4'hF); chk4("ar_an_lz", an_lz, 4'hF);
        chk4("ar_num", num_nz, 4'h0); chk1("ar_pend", pend_nz, 1'b0); chk1("ar_fd", fd_nz, 1'b0);
        step(2);
        rst_n = 1'b1; enable = 1'b1;
        step(3);
        chk4("ar_rel_an", an_nz, 4'hE); chk4("ar_rel_num", num_nz, 4'h0); chk1("ar_rel_pend", pend_nz, 1'b0);
        step(10);
        chk4("ar_f2_num1", num_nz, 4'h0); chk4("ar_f2_an1", an_nz, 4'hD); chk1("ar_f2_pend", pend_nz, 1'b0);
        step(8);
        chk4("ar_f3_num1", num_nz, 4'h0); chk4("ar_f3_an1", an_nz, 4'hD);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not finish, got timeout, want finish");
        $fatal(1);
    end

endmodule
